piece_collision_engine: RTL

//  Parametrised, sequential successor to the combinational saved-block boundary check.

---
 rtl/piece_collision_engine.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/piece_collision_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piece_collision_engine: row-serial 4x4 tetromino vs saved-board checker  |
// | Optional wall kick on HOLD when PIECE_WALL_KICK_EN is defined.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module piece_collision_engine #(
  parameter int COLS  = 10,
  parameter int ROWS  = 24,
  parameter int POS_W = 6
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    req,
  output logic                    ready,
  input  logic [1:0]              op,
  input  logic signed [POS_W-1:0] piece_x,
  input  logic signed [POS_W-1:0] piece_y,
  input  logic [15:0]             piece_mask,
  input  logic [COLS*ROWS-1:0]    board,
  output logic                    done,
  output logic                    ok,
  output logic signed [1:0]       kick_dx
);
  localparam int BW   = COLS * ROWS;
  localparam int IDXW = $clog2(BW);
  localparam logic [1:0] OP_DOWN  = 2'd0;
  localparam logic [1:0] OP_LEFT  = 2'd1;
  localparam logic [1:0] OP_RIGHT = 2'd2;

`ifdef PIECE_WALL_KICK_EN
  localparam logic [1:0] OP_HOLD = 2'd3;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2, S_KICK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t                state_q, state_d;
  logic [1:0]            row_q, row_d;
  logic                  hit_q, hit_d;
  logic [BW-1:0]         board_q, board_d;
  logic [15:0]           mask_q, mask_d;
  logic signed [POS_W:0] tx_q, tx_d, ty_q, ty_d;
  logic                  ready_q, ready_d, done_q, done_d, ok_q, ok_d;
  logic signed [POS_W:0] dx, dy;
  logic                  scanning, row_hit, hit_any;
  int                    xi, yi, idx, kick_off;

`ifdef PIECE_WALL_KICK_EN
  logic [1:0]        op_q, op_d;
  logic signed [1:0] kick_off_q, kick_off_d, kick_dx_q, kick_dx_d;
  assign scanning = (state_q == S_SCAN) || (state_q == S_KICK);
  assign kick_off = int'(kick_off_q);
  assign kick_dx  = kick_dx_q;
`else
  assign scanning = (state_q == S_SCAN);
  assign kick_off = 0;
  assign kick_dx  = 2'sb00;
`endif

  assign ready = ready_q;
  assign done  = done_q;
  assign ok    = ok_q;

  always_comb begin
    dx = '0;
    dy = '0;
    case (op)
      OP_DOWN:  dy = (POS_W+1)'(1);
      OP_LEFT:  dx = '1;
      OP_RIGHT: dx = (POS_W+1)'(1);
      default:  ;
    endcase
  end

  // Cells above the top edge only collide through the column bounds.
  always_comb begin
    row_hit = 1'b0;
    xi      = 0;
    yi      = 0;
    idx     = 0;
    for (int c = 0; c < 4; c++) begin
      xi  = int'(tx_q) + c + kick_off;
      yi  = int'(ty_q) + int'(row_q);
      idx = yi * COLS + xi;
      if (mask_q[{row_q, c[1:0]}]) begin
        if (xi < 0 || xi >= COLS || yi >= ROWS)
          row_hit = 1'b1;
        else if (yi >= 0 && board_q[idx[IDXW-1:0]])
          row_hit = 1'b1;
      end
    end
  end

  assign hit_any = hit_q | row_hit;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    hit_d   = hit_q;
    board_d = board_q;
    mask_d  = mask_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
`ifdef PIECE_WALL_KICK_EN
    op_d       = op_q;
    kick_off_d = kick_off_q;
    kick_dx_d  = kick_dx_q;
`endif
    if (state_q == S_IDLE) begin
      if (req) begin
        state_d = S_SCAN;
        board_d = board;
        mask_d  = piece_mask;
        tx_d    = {piece_x[POS_W-1], piece_x} + dx;
        ty_d    = {piece_y[POS_W-1], piece_y} + dy;
        row_d   = 2'd0;
        hit_d   = 1'b0;
        ready_d = 1'b0;
`ifdef PIECE_WALL_KICK_EN
        op_d       = op;
        kick_off_d = 2'sb00;
`endif
      end
    end else if (scanning) begin
      row_d = row_q + 2'd1;
      hit_d = hit_any;
      if (row_q == 2'd3) begin
`ifdef PIECE_WALL_KICK_EN
        // Rescan order: in place, then one column left, then one column right.
        if (hit_any && op_q == OP_HOLD && kick_off_q != 2'sb01) begin
          state_d    = S_KICK;
          hit_d      = 1'b0;
          kick_off_d = (kick_off_q == 2'sb00) ? 2'sb11 : 2'sb01;
        end else begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          ok_d      = ~hit_any;
          kick_dx_d = hit_any ? 2'sb00 : kick_off_q;
        end
`else
        state_d = S_DONE;
        done_d  = 1'b1;
        ok_d    = ~hit_any;
`endif
      end
    end else begin
      state_d = S_IDLE;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      row_q   <= 2'd0;
      hit_q   <= 1'b0;
      board_q <= '0;
      mask_q  <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
`ifdef PIECE_WALL_KICK_EN
      op_q       <= 2'd0;
      kick_off_q <= 2'sb00;
      kick_dx_q  <= 2'sb00;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      hit_q   <= hit_d;
      board_q <= board_d;
      mask_q  <= mask_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
`ifdef PIECE_WALL_KICK_EN
      op_q       <= op_d;
      kick_off_q <= kick_off_d;
      kick_dx_q  <= kick_dx_d;
`endif
    end
  end

endmodule
`default_nettype wire
